// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the core and slow_memory.
// Word accesses hit in zero cycles; misses evict/refill whole 128-bit blocks and stall the core.
module dcache_wb #(
    parameter int NUM_BLOCKS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = 28 - IDX_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;

    logic [127:0]           data_q [NUM_BLOCKS];
    logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]  valid_q;
    logic [NUM_BLOCKS-1:0]  dirty_q;

    logic [1:0]   state_q,     state_d;
    logic         mem_read_q,  mem_read_d;
    logic         mem_write_q, mem_write_d;
    logic [27:0]  mem_addr_q,  mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;
    logic [27:0]  miss_addr_q, miss_addr_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             req;
    logic             hit;
    logic             fill;
    logic             store_hit;
    logic [127:0]     rd_line;
    logic [127:0]     wr_line;

    assign idx      = proc_addr[IDX_W+1:2];
    assign tag      = proc_addr[29:IDX_W+2];
    assign word     = proc_addr[1:0];
    assign miss_idx = miss_addr_q[IDX_W-1:0];
    assign miss_tag = miss_addr_q[27:IDX_W];

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        req        = proc_read | proc_write;
        hit        = valid_q[idx] && (tag_q[idx] == tag);
        proc_stall = req && !((state_q == S_IDLE) && hit);
        rd_line    = data_q[idx];
        proc_rdata = rd_line[{word, 5'd0} +: 32];
        // A simultaneous read and write is a store; only the write path updates the line.
        wr_line    = rd_line;
        wr_line[{word, 5'd0} +: 32] = proc_wdata;
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miss_addr_d = miss_addr_q;
        fill        = 1'b0;
        store_hit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && hit) begin
                    store_hit = proc_write;
                end else if (req) begin
                    miss_addr_d = proc_addr[29:2];
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d     = S_WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[idx], idx};
                        mem_wdata_d = data_q[idx];
                    end else begin
                        state_d    = S_ALLOCATE;
                        mem_read_d = 1'b1;
                        mem_addr_d = proc_addr[29:2];
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = miss_addr_q;
                    state_d     = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (mem_ready) begin
                    mem_read_d = 1'b0;
                    fill       = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miss_addr_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_addr_q <= miss_addr_d;
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
                dirty_q[miss_idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // NOTE: data and tag arrays have no reset; cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill) begin
                data_q[miss_idx] <= mem_rdata;
                tag_q[miss_idx]  <= miss_tag;
            end else if (store_hit) begin
                data_q[idx] <= wr_line;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: directed vector table, reset-abort sequence, then random accesses
// checked against a word-level cache/memory model.
module tb_dcache_wb;

    localparam int NB    = 8;
    localparam int TAG_W = 25;

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    always #5 clk = ~clk;

    dcache_wb #(.NUM_BLOCKS(NB)) dut (
        .clk(clk), .rst(rst),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: cache lines as four words each, memory as a sparse block store.
    logic             m_valid [NB];
    logic             m_dirty [NB];
    logic [TAG_W-1:0] m_tag   [NB];
    logic [31:0]      m_word  [NB][4];
    logic [127:0]     mem_m   [logic [27:0]];

    function automatic logic [127:0] blk_of(input logic [27:0] ba);
        logic [127:0] b;
        if (mem_m.exists(ba)) return mem_m[ba];
        for (int k = 0; k < 4; k++) b[32*k +: 32] = {2'(k), 2'b10, ba};
        return b;
    endfunction

    function automatic logic [127:0] line_of(input int i);
        return {m_word[i][3], m_word[i][2], m_word[i][1], m_word[i][0]};
    endfunction

    // Called just after a falling edge; returns just after a falling edge with the request dropped.
    task automatic access(input logic rd, input logic wr, input logic [29:0] addr,
                          input logic [31:0] wd, output logic o_stall, output logic o_wb,
                          output logic [127:0] o_wbdata, output logic [31:0] o_rdata);
        int           idx, w, n;
        logic [TAG_W-1:0] tg;
        logic [27:0]  ba, vba;
        logic [127:0] blk;
        bit           hit;
        idx = int'((addr / 4) % NB);
        w   = int'(addr % 4);
        tg  = TAG_W'(addr / (4 * NB));
        ba  = 28'(addr / 4);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        o_wb = 1'b0;
        o_wbdata = '0;
        proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
        #1;
        o_stall = proc_stall;
        check("stall_on_request", proc_stall, !hit);
        if (!hit) begin
            @(negedge clk);
            if (m_valid[idx] && m_dirty[idx]) begin
                vba = 28'(m_tag[idx] * NB + idx);
                check("wb_mem_write", mem_write, 1'b1);
                check("wb_mem_read", mem_read, 1'b0);
                check("wb_mem_addr", mem_addr, vba);
                check("wb_mem_wdata", mem_wdata, line_of(idx));
                o_wb = 1'b1;
                o_wbdata = mem_wdata;
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(negedge clk);
                    check("wb_hold", mem_write, 1'b1);
                    check("wb_stall", proc_stall, 1'b1);
                end
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                mem_m[vba] = line_of(idx);
            end
            check("alloc_mem_read", mem_read, 1'b1);
            check("alloc_mem_write", mem_write, 1'b0);
            check("alloc_mem_addr", mem_addr, ba);
            check("alloc_stall", proc_stall, 1'b1);
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                check("alloc_hold", mem_read, 1'b1);
            end
            blk = blk_of(ba);
            mem_rdata = blk;
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = {4{$urandom}};
            for (int k = 0; k < 4; k++) m_word[idx][k] = blk[32*k +: 32];
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            check("refill_stall", proc_stall, 1'b0);
            check("refill_mem_read", mem_read, 1'b0);
        end else begin
            check("hit_mem_read", mem_read, 1'b0);
            check("hit_mem_write", mem_write, 1'b0);
        end
        o_rdata = proc_rdata;
        if (!wr) begin
            check("read_data", proc_rdata, m_word[idx][w]);
        end else begin
            m_word[idx][w] = wd;
            m_dirty[idx]   = 1'b1;
        end
        @(negedge clk);
        proc_read = 1'b0;
        proc_write = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wd;
        logic        exp_stall;
        logic        exp_wb;
        logic [31:0] exp_wbw2;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic         o_stall, o_wb;
        logic [127:0] o_wbdata;
        logic [31:0]  o_rdata;
        logic [29:0]  a;
        int           op;

        vecs[0] = '{1'b1, 1'b0, 30'h10, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 30'h11, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 30'h12, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 30'h32, 32'h0,        1'b1, 1'b1, 32'h12345678, 1'b1, 32'h0C0C0002};
        vecs[5] = '{1'b1, 1'b1, 30'h32, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 30'h32, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'hA5A5A5A5};
        vecs[7] = '{1'b1, 1'b0, 30'h10, 32'h0,        1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 32'hDEADBEEF};
        vecs[8] = '{1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h12345678};

        mem_m[28'h4] = {32'hCAFE0003, 32'hCAFE0002, 32'hDEADBEEF, 32'hDEADBEEF};
        mem_m[28'hC] = {32'h0C0C0003, 32'h0C0C0002, 32'h0C0C0001, 32'h0C0C0000};
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end

        rst = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_stall", proc_stall, 1'b0);
        check("reset_mem_read", mem_read, 1'b0);
        check("reset_mem_write", mem_write, 1'b0);
        check("reset_mem_addr", mem_addr, 28'h0);
        check("reset_mem_wdata", mem_wdata, 128'h0);

        for (int i = 0; i < 9; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, o_stall, o_wb, o_wbdata, o_rdata);
            check($sformatf("vec%0d_stall", i), o_stall, vecs[i].exp_stall);
            check($sformatf("vec%0d_wb", i), o_wb, vecs[i].exp_wb);
            if (vecs[i].exp_wb) check($sformatf("vec%0d_wb_word2", i), o_wbdata[95:64], vecs[i].exp_wbw2);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].exp_rdata);
        end

        // Reset during ALLOCATE aborts the refill; a late mem_ready must not fill the line.
        proc_read = 1'b1; proc_addr = 30'h40;
        #1;
        check("abort_stall", proc_stall, 1'b1);
        @(negedge clk);
        check("abort_mem_read", mem_read, 1'b1);
        check("abort_mem_addr", mem_addr, 28'h10);
        rst = 1'b1; proc_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rst_mem_read", mem_read, 1'b0);
        check("abort_rst_mem_write", mem_write, 1'b0);
        check("abort_rst_mem_addr", mem_addr, 28'h0);
        mem_rdata = {4{32'hBAD0BAD0}};
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("late_ready_mem_read", mem_read, 1'b0);
        check("late_ready_mem_write", mem_write, 1'b0);
        check("late_ready_stall", proc_stall, 1'b0);
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        access(1'b1, 1'b0, 30'h40, 32'h0, o_stall, o_wb, o_wbdata, o_rdata);
        check("after_abort_miss_0x40", o_stall, 1'b1);
        access(1'b1, 1'b0, 30'h10, 32'h0, o_stall, o_wb, o_wbdata, o_rdata);
        check("after_reset_miss_0x10", o_stall, 1'b1);
        check("after_reset_no_wb", o_wb, 1'b0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: a[29:5] = 25'h0;
                1: a[29:5] = 25'h1;
                2: a[29:5] = 25'h2;
                default: a[29:5] = 25'h1FFFFFF;
            endcase
            a[4:0] = 5'($urandom_range(0, 31));
            op = $urandom_range(0, 3);
            access(op != 2, op >= 2, a, $urandom, o_stall, o_wb, o_wbdata, o_rdata);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
